// File: rtl/shifter_pkg.sv
// Shared types and limits for the shifter_pipe barrel-shifter pipeline.
package shifter_pkg;

  localparam int unsigned MIN_WIDTH = 8;
  localparam int unsigned MAX_WIDTH = 64;

  typedef enum logic [1:0] {
    MODE_SRL = 2'b00,
    MODE_SRA = 2'b01,
    MODE_SLL = 2'b10,
    MODE_ROR = 2'b11
  } shift_mode_t;

  // Only the right shifts drop bits off the LSB end into the sticky bit.
  function automatic logic mode_drops_bits(shift_mode_t m);
    return (m == MODE_SRL) || (m == MODE_SRA);
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One fixed 2^K level of the shifter pipeline plus its pipeline register.
// Sticky accumulation is present only when SHIFTER_PIPE_STICKY_EN is defined.
module shift_stage
  import shifter_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int K     = 0,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [SHW-1:0]   shamt_i,
  input  shift_mode_t      mode_i,
`ifdef SHIFTER_PIPE_STICKY_EN
  input  logic             sticky_i,
  output logic             sticky_o,
`endif
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [SHW-1:0]   shamt_o,
  output shift_mode_t      mode_o
);

  localparam int unsigned AMT = 2 ** K;

  logic             valid_q;
  logic [WIDTH-1:0] data_d, data_q;
  logic [SHW-1:0]   shamt_q;
  shift_mode_t      mode_q;

  always_comb begin
    data_d = data_i;
    if (shamt_i[K]) begin
      case (mode_i)
        MODE_SRL: data_d = data_i >> AMT;
        MODE_SRA: data_d = $unsigned($signed(data_i) >>> AMT);
        MODE_SLL: data_d = data_i << AMT;
        MODE_ROR: data_d = (data_i >> AMT) | (data_i << (WIDTH - AMT));
        default:  data_d = data_i;
      endcase
    end
  end

`ifdef SHIFTER_PIPE_STICKY_EN
  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] LOW_MASK = ALL_ONES >> (WIDTH - AMT);

  logic sticky_d, sticky_q;

  always_comb begin
    sticky_d = sticky_i;
    if (shamt_i[K] && mode_drops_bits(mode_i))
      sticky_d = sticky_i | (|(data_i & LOW_MASK));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      sticky_q <= 1'b0;
    else if (adv) sticky_q <= sticky_d;
  end

  assign sticky_o = sticky_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      shamt_q <= '0;
      mode_q  <= MODE_SRL;
    end else if (adv) begin
      valid_q <= valid_i;
      data_q  <= data_d;
      shamt_q <= shamt_i;
      mode_q  <= mode_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign shamt_o = shamt_q;
  assign mode_o  = mode_q;

endmodule

// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter: SHW stages, LSB shift level first, one global stall.
// Define SHIFTER_PIPE_STICKY_EN to add the out_sticky port and sticky registers.
module shifter_pipe
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef SHIFTER_PIPE_STICKY_EN
  ,output logic            out_sticky
`endif
);

  if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH || (WIDTH & (WIDTH - 1)) != 0
      || SHW != $clog2(WIDTH)) begin : g_bad_cfg
    $error("shifter_pipe: WIDTH must be a power of two in 8..64 and SHW derived");
  end

  logic             adv;
  logic             valid_p [SHW+1];
  logic [WIDTH-1:0] data_p  [SHW+1];
  logic [SHW-1:0]   shamt_p [SHW+1];
  shift_mode_t      mode_p  [SHW+1];

  // The whole pipe moves as one: any free slot at the output lets every stage load.
  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  assign valid_p[0] = in_valid;
  assign data_p[0]  = in_data;
  assign shamt_p[0] = in_shamt;
  assign mode_p[0]  = shift_mode_t'(in_mode);

`ifdef SHIFTER_PIPE_STICKY_EN
  logic sticky_p [SHW+1];
  assign sticky_p[0] = 1'b0;
  assign out_sticky  = sticky_p[SHW];
`endif

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    shift_stage #(
      .WIDTH (WIDTH),
      .K     (k)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .adv      (adv),
      .valid_i  (valid_p[k]),
      .data_i   (data_p[k]),
      .shamt_i  (shamt_p[k]),
      .mode_i   (mode_p[k]),
`ifdef SHIFTER_PIPE_STICKY_EN
      .sticky_i (sticky_p[k]),
      .sticky_o (sticky_p[k+1]),
`endif
      .valid_o  (valid_p[k+1]),
      .data_o   (data_p[k+1]),
      .shamt_o  (shamt_p[k+1]),
      .mode_o   (mode_p[k+1])
    );
  end

  assign out_valid = valid_p[SHW];
  assign out_data  = data_p[SHW];

  logic unused_tail;
  assign unused_tail = ^{shamt_p[SHW], mode_p[SHW]};

endmodule

// File: tb/tb_shifter_pipe.sv
// Self-checking bench for shifter_pipe: WIDTH=32 and WIDTH=8 instances vs a reference model.
module tb_shifter_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  localparam int unsigned SH32 = 5;

  logic        v32, rdy32, ov32, or32;
  logic [31:0] d32, od32;
  logic [4:0]  sh32;
  logic [1:0]  m32;
  logic        v8, rdy8, ov8, or8;
  logic [7:0]  d8, od8;
  logic [2:0]  sh8;
  logic [1:0]  m8;
`ifdef SHIFTER_PIPE_STICKY_EN
  logic        os32, os8;
`endif

  shifter_pipe #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(v32), .in_ready(rdy32), .in_data(d32),
    .in_shamt(sh32), .in_mode(m32), .out_valid(ov32), .out_ready(or32),
`ifdef SHIFTER_PIPE_STICKY_EN
    .out_sticky(os32),
`endif
    .out_data(od32)
  );

  shifter_pipe #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8), .in_data(d8),
    .in_shamt(sh8), .in_mode(m8), .out_valid(ov8), .out_ready(or8),
`ifdef SHIFTER_PIPE_STICKY_EN
    .out_sticky(os8),
`endif
    .out_data(od8)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Whole-word reference: {sticky, result} for a w-bit operand.
  function automatic logic [64:0] model(input logic [63:0] d, input int unsigned w,
                                        input int unsigned sh, input logic [1:0] m);
    logic [63:0] mask, r, sign, low;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    sign = (d >> (w - 1)) & 64'd1;
    low  = (64'd1 << sh) - 64'd1;
    case (m)
      2'b00:   r = (d >> sh) & mask;
      2'b01:   r = ((d >> sh) | ((sign != 0) ? (mask & ~(mask >> sh)) : 64'd0)) & mask;
      2'b10:   r = (d << sh) & mask;
      default: r = ((d >> sh) | (d << (w - sh))) & mask;
    endcase
    return {(!m[1]) && ((d & low) != 0), r};
  endfunction

  typedef struct { logic [63:0] d; logic s; } exp_t;
  exp_t        q32[$], q8[$];
  int unsigned n_out32 = 0;

  always @(negedge clk) begin : mon32
    logic [64:0] r;
    exp_t        e;
    logic        hold;
    logic [31:0] hd;
    logic        hs;
    if (rst) begin
      q32.delete();
      hold = 1'b0;
    end else begin
      if (hold) begin
        check("hold_valid32", 64'(ov32), 64'd1);
        check("hold_data32", 64'(od32), 64'(hd));
`ifdef SHIFTER_PIPE_STICKY_EN
        check("hold_sticky32", 64'(os32), 64'(hs));
`endif
      end
      if (ov32 && or32) begin
        if (q32.size() == 0) check("stale32", 64'(ov32), 64'd0);
        else begin
          e = q32.pop_front();
          check("data32", 64'(od32), e.d);
`ifdef SHIFTER_PIPE_STICKY_EN
          check("sticky32", 64'(os32), 64'(e.s));
`endif
          n_out32++;
        end
      end
      if (v32 && rdy32) begin
        r = model(64'(d32), 32, 32'(sh32), m32);
        q32.push_back('{r[63:0], r[64]});
      end
      hold = ov32 && !or32;
      hd   = od32;
`ifdef SHIFTER_PIPE_STICKY_EN
      hs   = os32;
`else
      hs   = 1'b0;
`endif
    end
  end

  always @(negedge clk) begin : mon8
    logic [64:0] r;
    exp_t        e;
    logic        hold;
    logic [7:0]  hd;
    if (rst) begin
      q8.delete();
      hold = 1'b0;
    end else begin
      if (hold) check("hold_data8", 64'({ov8, od8}), 64'({1'b1, hd}));
      if (ov8 && or8) begin
        if (q8.size() == 0) check("stale8", 64'(ov8), 64'd0);
        else begin
          e = q8.pop_front();
          check("data8", 64'(od8), e.d);
`ifdef SHIFTER_PIPE_STICKY_EN
          check("sticky8", 64'(os8), 64'(e.s));
`endif
        end
      end
      if (v8 && rdy8) begin
        r = model(64'(d8), 8, 32'(sh8), m8);
        q8.push_back('{r[63:0], r[64]});
      end
      hold = ov8 && !or8;
      hd   = od8;
    end
  end

  // Single word through an idle pipe with a latency measurement.
  task automatic one32(input string tag, input logic [31:0] d, input logic [4:0] sh,
                       input logic [1:0] m, input logic [31:0] ed, input logic es);
    int unsigned cyc  = 0;
    bit          seen = 1'b0;
    @(posedge clk); #1;
    v32 = 1'b1; d32 = d; sh32 = sh; m32 = m; or32 = 1'b1;
    @(negedge clk);
    check({tag, "_rdy"}, 64'(rdy32), 64'd1);
    while (!seen && cyc < 20) begin
      @(posedge clk); #1;
      v32 = 1'b0;
      cyc++;
      @(negedge clk);
      if (ov32) seen = 1'b1;
    end
    check({tag, "_lat"}, 64'(cyc), 64'(SH32));
    check({tag, "_data"}, 64'(od32), 64'(ed));
`ifdef SHIFTER_PIPE_STICKY_EN
    check({tag, "_sticky"}, 64'(os32), 64'(es));
`else
    if (es === 1'bx) $display("sticky expectation unknown for %s", tag);
`endif
  endtask

  task automatic drain32(input int unsigned want);
    for (int i = 0; i < 30 && n_out32 != want; i++) @(negedge clk);
  endtask

  task automatic rand32(input int unsigned n);
    int unsigned idx = 0, cyc = 0;
    bit pend = 1'b0;
    while (idx < n && cyc < n * 10) begin
      @(posedge clk); #1;
      cyc++;
      if (!pend) begin
        v32 = ($urandom_range(0, 4) != 0);
        d32 = $urandom;
        sh32 = 5'($urandom_range(0, 31));
        m32 = 2'($urandom_range(0, 3));
      end
      or32 = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (v32 && rdy32) begin idx++; pend = 1'b0; end
      else pend = v32;
    end
    @(posedge clk); #1;
    v32 = 1'b0; or32 = 1'b1;
    check("rand32_accepted", 64'(idx), 64'(n));
    repeat (12) @(negedge clk);
    check("rand32_drained", 64'(q32.size()), 64'd0);
  endtask

  task automatic rand8(input int unsigned n);
    int unsigned idx = 0, cyc = 0;
    bit pend = 1'b0;
    while (idx < n && cyc < n * 10) begin
      @(posedge clk); #1;
      cyc++;
      if (!pend) begin
        v8 = ($urandom_range(0, 4) != 0);
        d8 = 8'($urandom);
        sh8 = 3'($urandom_range(0, 7));
        m8 = 2'($urandom_range(0, 3));
      end
      or8 = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (v8 && rdy8) begin idx++; pend = 1'b0; end
      else pend = v8;
    end
    @(posedge clk); #1;
    v8 = 1'b0; or8 = 1'b1;
    check("rand8_accepted", 64'(idx), 64'(n));
    repeat (10) @(negedge clk);
    check("rand8_drained", 64'(q8.size()), 64'd0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [31:0] wd [10];
    int unsigned idx, cyc, base, stale;

    rst = 1'b1;
    v32 = 1'b0; d32 = '0; sh32 = '0; m32 = '0; or32 = 1'b1;
    v8  = 1'b0; d8  = '0; sh8  = '0; m8  = '0; or8  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ov32", 64'(ov32), 64'd0);
    check("reset_od32", 64'(od32), 64'd0);
    check("reset_ov8", 64'(ov8), 64'd0);
    check("reset_od8", 64'(od8), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("reset_rdy32", 64'(rdy32), 64'd1);
    check("reset_rdy8", 64'(rdy8), 64'd1);

    one32("srl4",  32'hF000_000F, 5'd4,  2'b00, 32'h0F00_0000, 1'b1);
    one32("sra31", 32'h8000_0000, 5'd31, 2'b01, 32'hFFFF_FFFF, 1'b0);
    one32("ror1",  32'h0000_0001, 5'd1,  2'b11, 32'h8000_0000, 1'b0);
    one32("sll31", 32'h0000_0001, 5'd31, 2'b10, 32'h8000_0000, 1'b0);
    one32("sra4p", 32'h7FFF_FFF0, 5'd4,  2'b01, 32'h07FF_FFFF, 1'b0);
    one32("ror8",  32'h1234_5678, 5'd8,  2'b11, 32'h7812_3456, 1'b0);
    for (int m = 0; m < 4; m++)
      one32($sformatf("sh0_m%0d", m), 32'hA5C3_0F81, 5'd0, 2'(m), 32'hA5C3_0F81, 1'b0);

    // Back-to-back stream with a 3-cycle consumer stall in the middle.
    for (int i = 0; i < 10; i++) wd[i] = $urandom;
    base = n_out32; idx = 0; cyc = 0;
    while (idx < 10 && cyc < 100) begin
      @(posedge clk); #1;
      v32 = 1'b1; d32 = wd[idx]; sh32 = 5'(idx * 3); m32 = 2'(idx);
      or32 = !(cyc >= 6 && cyc < 9);
      cyc++;
      @(negedge clk);
      if (!or32) check("stall_rdy", 64'(rdy32), 64'd0);
      if (v32 && rdy32) idx++;
    end
    @(posedge clk); #1;
    v32 = 1'b0; or32 = 1'b1;
    drain32(base + 10);
    check("stall_count", 64'(n_out32 - base), 64'd10);

    // Reset with three words frozen in the pipe.
    or32 = 1'b0; idx = 0; cyc = 0;
    while (idx < 3 && cyc < 20) begin
      @(posedge clk); #1;
      v32 = 1'b1; d32 = $urandom; sh32 = 5'(idx + 1); m32 = 2'b00;
      cyc++;
      @(negedge clk);
      if (v32 && rdy32) idx++;
    end
    @(posedge clk); #1;
    v32 = 1'b0;
    for (int i = 0; i < 20 && !ov32; i++) @(negedge clk);
    check("rst_fill_ov", 64'(ov32), 64'd1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("rst_async_ov", 64'(ov32), 64'd0);
    check("rst_async_od", 64'(od32), 64'd0);
`ifdef SHIFTER_PIPE_STICKY_EN
    check("rst_async_sticky", 64'(os32), 64'd0);
`endif
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0; or32 = 1'b1;
    @(negedge clk);
    check("rst_rdy_after", 64'(rdy32), 64'd1);
    stale = 0;
    repeat (8) begin
      @(negedge clk);
      if (ov32) stale++;
    end
    check("rst_no_stale", 64'(stale), 64'd0);
    one32("post_rst", 32'h0000_00F0, 5'd4, 2'b00, 32'h0000_000F, 1'b0);

    rand32(300);
    rand8(1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
